cmac_seq: RTL and testbench

Sequencer for one shared CMAC datapath. It computes a complex dot product, Σ A[k]·B[k] for k = 0..len-1, over operand pairs streamed in through a valid/ready handshake. It drives the CMAC select and enable controls, captures the final accumulator value and presents it with a sticky overflow flag. It sits between the state-vector/gate-matrix fetch logic and the CMAC, and produces one output amplitude per `start`.

---
 rtl/cmac_seq_if.sv | 41 ++++
 rtl/cmac_seq.sv | 142 ++++++++++++++
 tb/tb_cmac_seq.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmac_seq_if.sv
// Operand, CMAC control and result bundle for the CMAC sequencer.
// Purely structural; adds no latency.
// Backpressure is carried by op_valid/op_ready and res_valid/res_ready.
interface cmac_seq_if #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
);
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              abs_mode;
   logic              busy;
   logic              op_valid;
   logic              op_ready;
   logic [DATA_W-1:0] op_a_r, op_a_i, op_b_r, op_b_i;
   logic [DATA_W-1:0] cmac_a_r, cmac_a_i, cmac_b_r, cmac_b_i;
   logic              cmac_acc, cmac_abs, cmac_acc_en, cmac_mult_en;
   logic [DATA_W-1:0] cmac_s_r, cmac_s_i;
   logic              cmac_overflow;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_r, res_i;
   logic              res_ovf;

   // sequencer side
   modport slave (
      input  start, len, abs_mode, op_valid, op_a_r, op_a_i, op_b_r, op_b_i,
             cmac_s_r, cmac_s_i, cmac_overflow, res_ready,
      output busy, op_ready, cmac_a_r, cmac_a_i, cmac_b_r, cmac_b_i,
             cmac_acc, cmac_abs, cmac_acc_en, cmac_mult_en,
             res_valid, res_r, res_i, res_ovf
   );

   // fetch logic / CMAC / result consumer side
   modport master (
      output start, len, abs_mode, op_valid, op_a_r, op_a_i, op_b_r, op_b_i,
             cmac_s_r, cmac_s_i, cmac_overflow, res_ready,
      input  busy, op_ready, cmac_a_r, cmac_a_i, cmac_b_r, cmac_b_i,
             cmac_acc, cmac_abs, cmac_acc_en, cmac_mult_en,
             res_valid, res_r, res_i, res_ovf
   );
endinterface

// File: rtl/cmac_seq.sv
// Sequences a shared CMAC through a complex dot product of len operand pairs.
// Latency: first pair 1 cycle, later pairs 2 cycles; result valid 2*len cycles after start (1 for len=0).
// Backpressure: op_valid low stalls FETCH with CMAC enables off; result held until res_ready.
module cmac_seq #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic       clk,
   input  logic       rst,
   cmac_seq_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, FETCH, ADD, OUT} state_t;

   state_t            state;
   logic [LEN_W-1:0]  cnt;
   logic              first;
   logic              abs_q;
   logic              ovf;
   logic              busy_q;
   logic              rdy_q;     // high exactly in FETCH
   logic              add_q;     // high exactly in ADD
   logic              rv_q;      // high exactly in OUT
   logic [DATA_W-1:0] res_r_q, res_i_q;

   logic op_fire;
   logic acc_en;
   logic mult_en;
   logic last;

   // Operands go straight to the CMAC; the sequencer only steers enables.
   assign bus.cmac_a_r = bus.op_a_r;
   assign bus.cmac_a_i = bus.op_a_i;
   assign bus.cmac_b_r = bus.op_b_r;
   assign bus.cmac_b_i = bus.op_b_i;

   // First accepted pair loads the accumulator directly, wiping any stale sum;
   // later pairs go to the mult register and are summed in the following ADD.
   assign op_fire = rdy_q & bus.op_valid;
   assign acc_en  = (op_fire & first) | add_q;
   assign mult_en = op_fire & ~first;
   assign last    = (cnt == LEN_W'(1));

   assign bus.cmac_acc     = add_q;
   assign bus.cmac_abs     = rdy_q & abs_q;
   assign bus.cmac_acc_en  = acc_en;
   assign bus.cmac_mult_en = mult_en;
   assign bus.op_ready     = rdy_q;
   assign bus.busy         = busy_q;
   assign bus.res_valid    = rv_q;
   assign bus.res_r        = res_r_q;
   assign bus.res_i        = res_i_q;
   assign bus.res_ovf      = ovf;

   // Control FSM with registered handshake/status outputs and result capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         first   <= 1'b0;
         abs_q   <= 1'b0;
         ovf     <= 1'b0;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b0;
         add_q   <= 1'b0;
         rv_q    <= 1'b0;
         res_r_q <= '0;
         res_i_q <= '0;
      end else begin
         // Overflow only counts on cycles where the CMAC actually updates.
         if ((acc_en | mult_en) & bus.cmac_overflow)
            ovf <= 1'b1;

         case (state)
            IDLE: begin
               if (bus.start) begin
                  cnt     <= bus.len;
                  abs_q   <= bus.abs_mode;
                  first   <= 1'b1;
                  ovf     <= 1'b0;
                  busy_q  <= 1'b1;
                  res_r_q <= '0;
                  res_i_q <= '0;
                  if (bus.len == '0) begin
                     state <= OUT;
                     rv_q  <= 1'b1;
                  end else begin
                     state <= FETCH;
                     rdy_q <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (op_fire) begin
                  if (first) begin
                     first <= 1'b0;
                     cnt   <= cnt - 1'b1;
                     if (last) begin
                        res_r_q <= bus.cmac_s_r;
                        res_i_q <= bus.cmac_s_i;
                        state   <= OUT;
                        rdy_q   <= 1'b0;
                        rv_q    <= 1'b1;
                     end
                  end else begin
                     state <= ADD;
                     rdy_q <= 1'b0;
                     add_q <= 1'b1;
                  end
               end
            end
            ADD: begin
               cnt   <= cnt - 1'b1;
               add_q <= 1'b0;
               if (last) begin
                  res_r_q <= bus.cmac_s_r;
                  res_i_q <= bus.cmac_s_i;
                  state   <= OUT;
                  rv_q    <= 1'b1;
               end else begin
                  state <= FETCH;
                  rdy_q <= 1'b1;
               end
            end
            OUT: begin
               if (bus.res_ready) begin
                  state  <= IDLE;
                  rv_q   <= 1'b0;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               rdy_q <= 1'b0;
               add_q <= 1'b0;
               rv_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmac_seq.sv
// Directed bench for cmac_seq with a behavioural Q16.16 CMAC attached.
// The CMAC result output is combinational (next accumulator value) so the
// sequencer can capture it on the edge that commits the last update.
module tb_cmac_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   localparam logic [31:0] BIG = 32'h7FFF_0000;

   cmac_seq_if #(.DATA_W(32), .LEN_W(8)) bus();
   cmac_seq #(.DATA_W(32), .LEN_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // ---------------- behavioural CMAC ----------------
   logic [31:0] mult_r = 32'h0BAD_0001, mult_i = 32'h0BAD_0002;
   logic [31:0] acc_r  = 32'h1234_5678, acc_i  = 32'h0765_4321;
   logic signed [63:0] ar, ai, br, bi, pr, pi;
   logic signed [32:0] sr, si;

   // product / sum and overflow of the operation currently selected
   always_comb begin
      ar = {{32{bus.cmac_a_r[31]}}, bus.cmac_a_r};
      ai = {{32{bus.cmac_a_i[31]}}, bus.cmac_a_i};
      br = {{32{bus.cmac_b_r[31]}}, bus.cmac_b_r};
      bi = {{32{bus.cmac_b_i[31]}}, bus.cmac_b_i};
      pr = (ar * br - ai * bi) >>> 16;
      pi = (ar * bi + ai * br) >>> 16;
      sr = {mult_r[31], mult_r} + {acc_r[31], acc_r};
      si = {mult_i[31], mult_i} + {acc_i[31], acc_i};
      if (bus.cmac_acc) begin
         bus.cmac_s_r      = sr[31:0];
         bus.cmac_s_i      = si[31:0];
         bus.cmac_overflow = (sr[32] != sr[31]) || (si[32] != si[31]);
      end else begin
         bus.cmac_s_r      = pr[31:0];
         bus.cmac_s_i      = pi[31:0];
         bus.cmac_overflow = (pr[63:31] != {33{pr[31]}}) || (pi[63:31] != {33{pi[31]}});
      end
   end

   // CMAC registers
   always @(posedge clk) begin
      if (bus.cmac_mult_en) begin
         mult_r <= pr[31:0];
         mult_i <= pi[31:0];
      end
      if (bus.cmac_acc_en) begin
         acc_r <= bus.cmac_s_r;
         acc_i <= bus.cmac_s_i;
      end
   end

   // ---------------- control monitor ----------------
   int   n_mult = 0, n_acc = 0, n_both = 0, n_stall_en = 0;
   int   n_add_rdy = 0, n_abs_bad = 0, n_idle_ctl = 0;
   logic abs_exp = 1'b0;

   // tallies control activity after the bench has driven inputs for the cycle
   always @(negedge clk) begin
      #2;
      if (bus.cmac_mult_en) n_mult++;
      if (bus.cmac_acc_en) n_acc++;
      if (bus.cmac_mult_en && bus.cmac_acc_en) n_both++;
      if (bus.op_ready && !bus.op_valid && (bus.cmac_mult_en || bus.cmac_acc_en)) n_stall_en++;
      if (bus.cmac_acc && bus.op_ready) n_add_rdy++;
      if (bus.cmac_abs !== (bus.op_ready ? abs_exp : 1'b0)) n_abs_bad++;
      if (!bus.op_ready && !bus.cmac_acc &&
          (bus.cmac_mult_en || bus.cmac_acc_en || bus.cmac_abs)) n_idle_ctl++;
   end

   // ---------------- stimulus helpers ----------------
   logic [31:0] pa_r[8], pa_i[8], pb_r[8], pb_i[8];

   task automatic set_pair(input int k, input logic [31:0] a_r, input logic [31:0] a_i,
                           input logic [31:0] b_r, input logic [31:0] b_i);
      pa_r[k] = a_r; pa_i[k] = a_i; pb_r[k] = b_r; pb_i[k] = b_i;
   endtask

   // large operands on invalid cycles make ungated overflow visible
   task automatic idle_ops();
      bus.op_valid = 1'b0;
      bus.op_a_r = BIG; bus.op_a_i = BIG; bus.op_b_r = BIG; bus.op_b_i = BIG;
   endtask

   task automatic take();
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
   endtask

   // Pulse start now (caller sits on a negedge) and feed n pairs; pairs after
   // the first wait `stall` invalid cycles. Returns cycles from start to res_valid.
   task automatic run(input int n, input int stall, input logic abs_m,
                      output int lat, output bit tmo);
      int idx;
      int sc;
      bit fire;
      idx = 0; sc = 0; lat = 0;
      abs_exp      = abs_m;
      bus.len      = 8'(n);
      bus.abs_mode = abs_m;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      while (!bus.res_valid && lat < 200) begin
         if (idx < n && (idx == 0 || sc >= stall)) begin
            bus.op_valid = 1'b1;
            bus.op_a_r = pa_r[idx]; bus.op_a_i = pa_i[idx];
            bus.op_b_r = pb_r[idx]; bus.op_b_i = pb_i[idx];
         end else begin
            idle_ops();
            if (idx < n) sc++;
         end
         fire = bus.op_valid && bus.op_ready;
         @(negedge clk);
         lat++;
         if (fire) begin
            idx++;
            sc = 0;
         end
      end
      idle_ops();
      tmo = !bus.res_valid;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy, bus.op_ready, bus.res_valid, bus.res_ovf} !== 4'b0) begin
         failures++;
         $display("FAIL reset_status: got busy/rdy/rv/ovf=%b expected 0000",
                  {bus.busy, bus.op_ready, bus.res_valid, bus.res_ovf});
      end
      checks++;
      if ({bus.cmac_acc, bus.cmac_abs, bus.cmac_acc_en, bus.cmac_mult_en} !== 4'b0) begin
         failures++;
         $display("FAIL reset_ctl: got acc/abs/acc_en/mult_en=%b expected 0000",
                  {bus.cmac_acc, bus.cmac_abs, bus.cmac_acc_en, bus.cmac_mult_en});
      end
      checks++;
      if ({bus.res_r, bus.res_i} !== 64'h0) begin
         failures++;
         $display("FAIL reset_res: got %h/%h expected 0/0", bus.res_r, bus.res_i);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.op_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: got busy=%b rdy=%b expected 0 0", bus.busy, bus.op_ready);
      end
   endtask

   task automatic test_len1();
      int lat; bit tmo;
      set_pair(0, 32'h0001_0000, 32'h0, 32'h0000_8000, 32'h0000_4000);
      run(1, 0, 1'b0, lat, tmo);
      checks++;
      if (tmo || lat != 2) begin
         failures++;
         $display("FAIL len1_latency: got %0d (timeout=%0b) expected 2", lat, tmo);
      end
      checks++;
      if (bus.res_r !== 32'h0000_8000 || bus.res_i !== 32'h0000_4000) begin
         failures++;
         $display("FAIL len1_result: got %h/%h expected 00008000/00004000", bus.res_r, bus.res_i);
      end
      checks++;
      if (bus.res_ovf !== 1'b0 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL len1_flags: got ovf=%b busy=%b expected 0 1", bus.res_ovf, bus.busy);
      end
      take();
      checks++;
      if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
         failures++;
         $display("FAIL len1_take: got busy=%b rv=%b expected 0 0", bus.busy, bus.res_valid);
      end
   endtask

   task automatic test_len4();
      int lat; bit tmo; int m0, a0, b0;
      for (int k = 0; k < 4; k++) set_pair(k, 32'h0001_0000, 32'h0, 32'h0000_4000, 32'h0);
      m0 = n_mult; a0 = n_acc; b0 = n_both;
      run(4, 0, 1'b0, lat, tmo);
      checks++;
      if (tmo || lat != 8) begin
         failures++;
         $display("FAIL len4_latency: got %0d (timeout=%0b) expected 8", lat, tmo);
      end
      checks++;
      if (bus.res_r !== 32'h0001_0000 || bus.res_i !== 32'h0) begin
         failures++;
         $display("FAIL len4_result: got %h/%h expected 00010000/00000000", bus.res_r, bus.res_i);
      end
      take();
      checks++;
      if (n_mult - m0 != 3 || n_acc - a0 != 4 || n_both - b0 != 0) begin
         failures++;
         $display("FAIL len4_enables: got mult=%0d acc=%0d both=%0d expected 3 4 0",
                  n_mult - m0, n_acc - a0, n_both - b0);
      end
   endtask

   // starts on the same negedge the previous take() ended on
   task automatic test_back_to_back();
      int lat; bit tmo;
      run(4, 0, 1'b0, lat, tmo);
      checks++;
      if (tmo || lat != 8) begin
         failures++;
         $display("FAIL b2b_latency: got %0d (timeout=%0b) expected 8", lat, tmo);
      end
      checks++;
      if (bus.res_r !== 32'h0001_0000 || bus.res_i !== 32'h0) begin
         failures++;
         $display("FAIL b2b_result: got %h/%h expected 00010000/00000000", bus.res_r, bus.res_i);
      end
      take();
   endtask

   task automatic test_stall();
      int lat; bit tmo; int s0, d0, x0, c0;
      // (1,0)(0.75,0) + (0,1)(0,1) + (0.5,0.5)(1,0) = (0.25, 0.5)
      set_pair(0, 32'h0001_0000, 32'h0, 32'h0000_C000, 32'h0);
      set_pair(1, 32'h0, 32'h0001_0000, 32'h0, 32'h0001_0000);
      set_pair(2, 32'h0000_8000, 32'h0000_8000, 32'h0001_0000, 32'h0);
      s0 = n_stall_en; d0 = n_add_rdy; x0 = n_abs_bad; c0 = n_idle_ctl;
      run(3, 2, 1'b1, lat, tmo);
      checks++;
      if (tmo || bus.res_r !== 32'h0000_4000 || bus.res_i !== 32'h0000_8000) begin
         failures++;
         $display("FAIL stall_result: got %h/%h (timeout=%0b) expected 00004000/00008000",
                  bus.res_r, bus.res_i, tmo);
      end
      checks++;
      if (n_stall_en != s0 || n_add_rdy != d0) begin
         failures++;
         $display("FAIL stall_ctl: got stall_en=%0d add_rdy=%0d expected 0 0",
                  n_stall_en - s0, n_add_rdy - d0);
      end
      checks++;
      if (n_abs_bad != x0 || n_idle_ctl != c0) begin
         failures++;
         $display("FAIL stall_abs: got abs_bad=%0d idle_ctl=%0d expected 0 0",
                  n_abs_bad - x0, n_idle_ctl - c0);
      end
      take();
   endtask

   task automatic test_overflow();
      int lat; bit tmo;
      set_pair(0, 32'h0001_0000, 32'h0, 32'h6000_0000, 32'h0);
      set_pair(1, 32'h0001_0000, 32'h0, 32'h6000_0000, 32'h0);
      run(2, 0, 1'b0, lat, tmo);
      checks++;
      if (tmo || bus.res_ovf !== 1'b1 || bus.res_r !== 32'hC000_0000) begin
         failures++;
         $display("FAIL ovf_set: got ovf=%b res_r=%h (timeout=%0b) expected 1 c0000000",
                  bus.res_ovf, bus.res_r, tmo);
      end
      take();
      // clean run with FETCH stalls carrying overflowing garbage operands
      set_pair(0, 32'h0001_0000, 32'h0, 32'h0000_8000, 32'h0000_4000);
      set_pair(1, 32'h0001_0000, 32'h0, 32'h0000_8000, 32'h0000_4000);
      run(2, 2, 1'b0, lat, tmo);
      checks++;
      if (tmo || bus.res_ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear: got ovf=%b (timeout=%0b) expected 0", bus.res_ovf, tmo);
      end
      checks++;
      if (bus.res_r !== 32'h0001_0000 || bus.res_i !== 32'h0000_8000) begin
         failures++;
         $display("FAIL ovf_clean_result: got %h/%h expected 00010000/00008000", bus.res_r, bus.res_i);
      end
      take();
   endtask

   task automatic test_len0();
      int lat; bit tmo; int m0, a0;
      m0 = n_mult; a0 = n_acc;
      run(0, 0, 1'b0, lat, tmo);
      checks++;
      if (tmo || lat != 1) begin
         failures++;
         $display("FAIL len0_latency: got %0d (timeout=%0b) expected 1", lat, tmo);
      end
      checks++;
      if (bus.res_r !== 32'h0 || bus.res_i !== 32'h0 || bus.res_ovf !== 1'b0) begin
         failures++;
         $display("FAIL len0_result: got %h/%h ovf=%b expected 0/0 0", bus.res_r, bus.res_i, bus.res_ovf);
      end
      take();
      checks++;
      if (n_mult != m0 || n_acc != a0) begin
         failures++;
         $display("FAIL len0_cmac_idle: got mult=%0d acc=%0d expected 0 0", n_mult - m0, n_acc - a0);
      end
   endtask

   task automatic test_hold();
      int lat; bit tmo;
      set_pair(0, 32'h0001_0000, 32'h0, 32'h0000_8000, 32'h0000_4000);
      run(1, 0, 1'b0, lat, tmo);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (bus.res_valid !== 1'b1 || bus.res_r !== 32'h0000_8000 || bus.res_i !== 32'h0000_4000) begin
            failures++;
            $display("FAIL hold_cycle%0d: got rv=%b %h/%h expected 1 00008000/00004000",
                     c, bus.res_valid, bus.res_r, bus.res_i);
         end
      end
      // start coinciding with the result handshake must be dropped
      bus.len = 8'd1; bus.start = 1'b1; bus.res_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.res_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.op_ready !== 1'b0) begin
         failures++;
         $display("FAIL hold_coincident_start: got busy=%b rdy=%b expected 0 0", bus.busy, bus.op_ready);
      end
   endtask

   task automatic test_reset_mid();
      int lat; bit tmo;
      for (int k = 0; k < 3; k++) set_pair(k, 32'h0001_0000, 32'h0, 32'h0000_4000, 32'h0);
      bus.len = 8'd3; bus.abs_mode = 1'b1; abs_exp = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op_valid = 1'b1;
      bus.op_a_r = pa_r[0]; bus.op_a_i = pa_i[0]; bus.op_b_r = pb_r[0]; bus.op_b_i = pb_i[0];
      @(negedge clk);
      // first pair accepted, still in FETCH waiting for the second
      idle_ops();
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.op_ready, bus.res_valid, bus.res_ovf,
           bus.cmac_acc, bus.cmac_abs, bus.cmac_acc_en, bus.cmac_mult_en} !== 8'b0) begin
         failures++;
         $display("FAIL rst_mid_outputs: got %b expected 00000000",
                  {bus.busy, bus.op_ready, bus.res_valid, bus.res_ovf,
                   bus.cmac_acc, bus.cmac_abs, bus.cmac_acc_en, bus.cmac_mult_en});
      end
      checks++;
      if ({bus.res_r, bus.res_i} !== 64'h0) begin
         failures++;
         $display("FAIL rst_mid_res: got %h/%h expected 0/0", bus.res_r, bus.res_i);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      set_pair(0, 32'h0001_0000, 32'h0, 32'h0000_8000, 32'h0000_4000);
      run(1, 0, 1'b0, lat, tmo);
      checks++;
      if (tmo || lat != 2 || bus.res_r !== 32'h0000_8000 || bus.res_i !== 32'h0000_4000) begin
         failures++;
         $display("FAIL rst_mid_rerun: got lat=%0d %h/%h (timeout=%0b) expected 2 00008000/00004000",
                  lat, bus.res_r, bus.res_i, tmo);
      end
      take();
   endtask

   // ---------------- sequence ----------------
   initial begin
      bus.start = 1'b0; bus.len = '0; bus.abs_mode = 1'b0; bus.res_ready = 1'b0;
      idle_ops();
      test_reset();
      test_len1();
      test_len4();
      test_back_to_back();
      test_stall();
      test_overflow();
      test_len0();
      test_hold();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
